hilo_muldiv_ctrl: RTL and testbench

Sequencer for the HI/LO multiply/divide resource used by the EX stage. It accepts decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO operations and runs a fixed-latency multiplier or a 32-step iterative divider. It owns the architectural HI/LO registers and raises a pipeline stall whenever a younger instruction needs HI/LO or the unit while an operation is in flight.

---
 rtl/hilo_muldiv_ctrl.sv | 126 ++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: HI/LO multiply/divide sequencer with pipeline stall generation
module hilo_muldiv_ctrl #(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        rd_hilo_req,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d;
  logic sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic legal, accept, op_signed, sa, sb, ge;
  logic signed [63:0] ma, mb, prod;
  logic [31:0] sh, nrem, nquo, qfix, rfix;
  assign legal = op_valid && op != 3'd0 && op != 3'd7;
  assign busy = state_q != IDLE;
  assign stall = busy && (legal || rd_hilo_req);
  assign accept = state_q == IDLE && legal && !flush;
  assign op_signed = op == 3'd1 || op == 3'd3;
  assign sa = op_signed && rs_data[31];
  assign sb = op_signed && rt_data[31];
  assign ma = {{32{sgn_q & a_q[31]}}, a_q};
  assign mb = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod = ma * mb;
  // Restoring step: remainder msb set means the shifted value already exceeds any 32-bit divisor
  assign sh = {rem_q[30:0], quo_q[31]};
  assign ge = rem_q[31] || sh >= b_q;
  assign nrem = ge ? sh - b_q : sh;
  assign nquo = {quo_q[30:0], ge};
  assign qfix = qneg_q ? -nquo : nquo;
  assign rfix = rneg_q ? -nrem : nrem;
  assign hi = hi_q;
  assign lo = lo_q;
  // Next-state: accept/decode in IDLE, count down and commit in MUL/DIV, flush aborts
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    a_d = a_q;
    b_d = b_q;
    quo_d = quo_q;
    rem_d = rem_q;
    sgn_d = sgn_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        if (op == 3'd5) hi_d = rs_data;
        if (op == 3'd6) lo_d = rs_data;
        if (op == 3'd1 || op == 3'd2) begin
          a_d = rs_data;
          b_d = rt_data;
          sgn_d = op_signed;
          cnt_d = 6'(MUL_LATENCY - 1);
          state_d = MUL;
        end
        if (op == 3'd3 || op == 3'd4) begin
          a_d = rs_data;
          b_d = sb ? -rt_data : rt_data;
          quo_d = sa ? -rs_data : rs_data;
          rem_d = '0;
          qneg_d = sa ^ sb;
          rneg_d = sa;
          cnt_d = 6'(DIV_CYCLES - 1);
          state_d = DIV;
        end
      end
    end else begin
      cnt_d = cnt_q - 6'd1;
      if (state_q == DIV) begin
        rem_d = nrem;
        quo_d = nquo;
      end
      if (cnt_q == 6'd0) begin
        state_d = IDLE;
        cnt_d = '0;
        hi_d = state_q == MUL ? prod[63:32] : (b_q == '0 ? a_q : rfix);
        lo_d = state_q == MUL ? prod[31:0] : (b_q == '0 ? '1 : qfix);
      end
    end
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      a_q <= '0;
      b_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      sgn_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      a_q <= a_d;
      b_q <= b_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      sgn_q <= sgn_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: directed and random checks of the HI/LO sequencer against a cycle-count model
module tb_hilo_muldiv_ctrl;
  localparam int ML = 3;
  localparam int DC = 32;
  logic clk = 0, rst_n = 0, op_valid = 0, rd_hilo_req = 0, flush = 0;
  logic [2:0] op = 0;
  logic [31:0] rs_data = 0, rt_data = 0;
  logic stall, busy;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;
  int m_rem = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  longint ma, mb, mr;
  logic e_stall;

  hilo_muldiv_ctrl #(.MUL_LATENCY(ML), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .rs_data(rs_data),
    .rt_data(rt_data), .rd_hilo_req(rd_hilo_req), .flush(flush), .stall(stall),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic legal(logic v, logic [2:0] o);
    return v && o >= 3'd1 && o <= 3'd6;
  endfunction

  assign e_stall = m_rem > 0 && (legal(op_valid, op) || rd_hilo_req);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining busy cycles plus a result computed with plain arithmetic at accept
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0;
      m_hi = 0;
      m_lo = 0;
    end else if (flush) begin
      m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (legal(op_valid, op)) begin
      if (op == 3'd5) m_hi = rs_data;
      if (op == 3'd6) m_lo = rs_data;
      ma = (op == 3'd1 || op == 3'd3) ? longint'($signed(rs_data)) : longint'({32'd0, rs_data});
      mb = (op == 3'd1 || op == 3'd3) ? longint'($signed(rt_data)) : longint'({32'd0, rt_data});
      if (op == 3'd1 || op == 3'd2) begin
        mr = ma * mb;
        p_hi = mr[63:32];
        p_lo = mr[31:0];
        m_rem = ML;
      end
      if (op == 3'd3 || op == 3'd4) begin
        if (rt_data == 0) begin
          p_lo = 32'hFFFFFFFF;
          p_hi = rs_data;
        end else begin
          mr = ma / mb;
          p_lo = mr[31:0];
          mr = ma % mb;
          p_hi = mr[31:0];
        end
        m_rem = DC;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 32'(busy), 32'(m_rem > 0));
      check("stall", 32'(stall), 32'(e_stall));
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    op_valid = 1;
    op = o;
    rs_data = a;
    rt_data = b;
    cyc();
    op_valid = 0;
    op = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (m_rem > 0 && n < 100) begin
      cyc();
      n++;
    end
    if (m_rem > 0) begin
      errors++;
      $display("FAIL wait_idle timeout got %0d expected 0", m_rem);
    end
  endtask

  initial begin
    int n;
    logic acc;
    #12 rst_n = 1;
    cyc();
    check("rst_busy", 32'(busy), 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_stall", 32'(stall), 0);
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    check("mult_lat", n, ML);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);
    issue(3'd2, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    check("multu_hi", hi, 32'h00000002);
    check("multu_lo", lo, 32'hFFFFFFFA);
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    check("div_lat", n, DC);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    issue(3'd4, 32'd100, 32'd7);
    wait_idle(n);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    issue(3'd4, 32'd7, 32'd0);
    wait_idle(n);
    check("dz_lo", lo, 32'hFFFFFFFF);
    check("dz_hi", hi, 32'd7);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    check("ovf_lo", lo, 32'h80000000);
    check("ovf_hi", hi, 32'd0);
    issue(3'd3, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) cyc();
    flush = 1;
    cyc();
    flush = 0;
    check("flush_busy", 32'(busy), 0);
    check("flush_hi", hi, 32'd0);
    check("flush_lo", lo, 32'h80000000);
    issue(3'd5, 32'h12345678, 32'd0);
    check("mthi", hi, 32'h12345678);
    issue(3'd6, 32'h9ABCDEF0, 32'd0);
    check("mtlo", lo, 32'h9ABCDEF0);
    issue(3'd4, 32'd1000, 32'd3);
    cyc();
    rd_hilo_req = 1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_rem == 0) break;
      if (stall) n++;
    end
    check("rd_stall_cycles", n, 31);
    check("rd_stall_end", 32'(stall), 0);
    cyc();
    rd_hilo_req = 0;
    issue(3'd3, 32'd50, 32'd5);
    op_valid = 1;
    op = 3'd1;
    rs_data = 32'hFFFFFFFE;
    rt_data = 32'd3;
    acc = 0;
    for (int i = 0; i < 60 && !acc; i++) begin
      acc = m_rem == 0;
      cyc();
    end
    op_valid = 0;
    op = 0;
    check("mult_after_div_acc", 32'(acc), 1);
    wait_idle(n);
    check("mult_after_div_lat", n, ML);
    check("mult_after_div_hi", hi, 32'hFFFFFFFF);
    check("mult_after_div_lo", lo, 32'hFFFFFFFA);
    issue(3'd2, 32'hFFFFFFFE, 32'd3);
    rd_hilo_req = 1;
    #2 rst_n = 0;
    #1;
    check("amid_busy", 32'(busy), 0);
    check("amid_stall", 32'(stall), 0);
    check("amid_hi", hi, 0);
    check("amid_lo", lo, 0);
    #2 rst_n = 1;
    rd_hilo_req = 0;
    cyc();
    for (int i = 0; i < 3000; i++) begin
      if (!(m_rem > 0 && legal(op_valid, op))) begin
        op_valid = $urandom_range(0, 2) != 0;
        op = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0: rs_data = 32'h80000000;
          1: rs_data = $urandom_range(0, 20);
          default: rs_data = $urandom;
        endcase
        case ($urandom_range(0, 4))
          0: rt_data = 32'd0;
          1: rt_data = 32'hFFFFFFFF;
          2: rt_data = $urandom_range(1, 9);
          default: rt_data = $urandom;
        endcase
      end
      rd_hilo_req = $urandom_range(0, 3) == 0;
      flush = $urandom_range(0, 49) == 0;
      cyc();
    end
    op_valid = 0;
    flush = 0;
    rd_hilo_req = 0;
    wait_idle(n);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
